gpu_prim_sequencer: RTL and testbench

Primitive-assembly controller for the graphics path at the writeback stage. It consumes decoded graphics commands (begin primitive, set vertex, end primitive), gathers vertices into triangles and presents each triangle as V1/V2/V3 to the GPU stage. It holds each triangle until the GPU accepts it and back-pressures the pipeline while the GPU stalls.

---
 rtl/gpu_prim_pkg.sv | 20 ++
 rtl/gpu_vertex_window.sv | 33 +++
 rtl/gpu_prim_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gpu_prim_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_prim_pkg.sv
// Shared encodings for the graphics primitive-assembly path.
// Command codes, primitive types and the sequencer state type.
package gpu_prim_pkg;

  localparam int VERTEX_REG_WIDTH = 30;

  localparam logic [1:0] CMD_NOP    = 2'd0;
  localparam logic [1:0] CMD_BEGIN  = 2'd1;
  localparam logic [1:0] CMD_VERTEX = 2'd2;
  localparam logic [1:0] CMD_END    = 2'd3;

  localparam logic PRIM_LIST  = 1'b0;
  localparam logic PRIM_STRIP = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } state_t;

endpackage

// File: rtl/gpu_vertex_window.sv
// Two-entry vertex window: w0 is older, w1 newest; count saturates at 2.
// Pushing while full keeps the last two vertices (strip retention).
module gpu_vertex_window
  import gpu_prim_pkg::*;
#(
  parameter int W = VERTEX_REG_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic [W-1:0] w0,
  output logic [W-1:0] w1,
  output logic [1:0]   count
);

  // Shift register with saturating fill count, updates on falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      w0    <= '0;
      w1    <= '0;
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else if (push) begin
      w0 <= w1;
      w1 <= din;
      if (count != 2'd2) count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/gpu_prim_sequencer.sv
// Primitive assembly: gathers vertices into triangles for the GPU stage.
// Strip support is built only when GPU_TRISTRIP_EN is defined.
module gpu_prim_sequencer
  import gpu_prim_pkg::*;
#(
  parameter int VTX_W = VERTEX_REG_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             I_CLOCK,
  input  logic             I_LOCK,
  input  logic             I_CmdValid,
  input  logic [1:0]       I_Cmd,
  input  logic             I_PrimType,
  input  logic [VTX_W-1:0] I_VertexData,
  input  logic             I_GPUStallSignal,
  output logic             O_Stall,
  output logic             O_PrimValid,
  output logic [VTX_W-1:0] O_VertexV1,
  output logic [VTX_W-1:0] O_VertexV2,
  output logic [VTX_W-1:0] O_VertexV3,
  output logic             O_PrimOpen,
  output logic [CNT_W-1:0] O_PrimCount,
  output logic             O_Error
);

  state_t state, state_nxt;

  logic             accept, take;
  logic             err_set, load, strip;
  logic             win_clear, win_push;
  logic [VTX_W-1:0] w0, w1;
  logic [1:0]       vc;
  logic [VTX_W-1:0] t1, t2, t3;

`ifdef GPU_TRISTRIP_EN
  logic prim_type, type_nxt;
  logic parity, par_nxt;
`else
  logic unused_prim_type;
  assign unused_prim_type = I_PrimType;
`endif

  assign O_Stall    = O_PrimValid & I_GPUStallSignal;
  assign accept     = I_CmdValid & ~O_Stall;
  assign take       = O_PrimValid & ~I_GPUStallSignal;
  assign O_PrimOpen = (state == ST_OPEN);

  gpu_vertex_window #(
    .W(VTX_W)
  ) u_win (
    .clk   (I_CLOCK),
    .rst_n (I_LOCK),
    .clear (win_clear),
    .push  (win_push),
    .din   (I_VertexData),
    .w0    (w0),
    .w1    (w1),
    .count (vc)
  );

  // Command decode: next state, window control and triangle load.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    win_clear = 1'b0;
    win_push  = 1'b0;
    load      = 1'b0;
    t1        = w0;
    t2        = w1;
    t3        = I_VertexData;
`ifdef GPU_TRISTRIP_EN
    type_nxt  = prim_type;
    par_nxt   = parity;
    strip     = (prim_type == PRIM_STRIP);
`else
    strip     = 1'b0;
`endif
    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (I_Cmd == CMD_BEGIN) begin
            state_nxt = ST_OPEN;
            win_clear = 1'b1;
`ifdef GPU_TRISTRIP_EN
            type_nxt  = I_PrimType;
            par_nxt   = 1'b0;
`endif
          end else if (I_Cmd != CMD_NOP) begin
            err_set = 1'b1;
          end
        end
        ST_OPEN: begin
          unique case (1'b1)
            (I_Cmd == CMD_BEGIN): begin
              err_set   = 1'b1;
              win_clear = 1'b1;
`ifdef GPU_TRISTRIP_EN
              type_nxt  = I_PrimType;
              par_nxt   = 1'b0;
`endif
            end
            (I_Cmd == CMD_VERTEX): begin
              if (vc != 2'd2) begin
                win_push = 1'b1;
              end else begin
                load = 1'b1;
                if (strip) begin
                  win_push = 1'b1;
`ifdef GPU_TRISTRIP_EN
                  par_nxt  = ~parity;
                  if (parity) begin
                    t1 = w1;
                    t2 = w0;
                  end
`endif
                end else begin
                  win_clear = 1'b1;
                end
              end
            end
            (I_Cmd == CMD_END): begin
              state_nxt = ST_IDLE;
              win_clear = 1'b1;
              if (strip) err_set = (vc == 2'd1);
              else       err_set = (vc != 2'd0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // State, output triangle registers, counter and sticky error.
  always_ff @(negedge I_CLOCK) begin
    if (!I_LOCK) begin
      state       <= ST_IDLE;
      O_PrimValid <= 1'b0;
      O_VertexV1  <= '0;
      O_VertexV2  <= '0;
      O_VertexV3  <= '0;
      O_PrimCount <= '0;
      O_Error     <= 1'b0;
`ifdef GPU_TRISTRIP_EN
      prim_type   <= PRIM_LIST;
      parity      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (err_set) O_Error <= 1'b1;
      if (take) O_PrimCount <= O_PrimCount + 1'b1;
      if (load) begin
        O_PrimValid <= 1'b1;
        O_VertexV1  <= t1;
        O_VertexV2  <= t2;
        O_VertexV3  <= t3;
      end else if (take) begin
        O_PrimValid <= 1'b0;
      end
`ifdef GPU_TRISTRIP_EN
      prim_type <= type_nxt;
      parity    <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gpu_prim_sequencer.sv
// Bench for gpu_prim_sequencer: directed table, corner sequences, random vs model.
// Strip checks are compiled only when GPU_TRISTRIP_EN is defined.
module tb_gpu_prim_sequencer;
  import gpu_prim_pkg::*;

  localparam int VW = 30;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          lock = 1'b0;
  logic          cv = 1'b0;
  logic [1:0]    cmd = CMD_NOP;
  logic          pt = 1'b0;
  logic [VW-1:0] vd = '0;
  logic          gs = 1'b0;

  logic          o_stall, o_pv, o_open, o_err;
  logic [VW-1:0] o_v1, o_v2, o_v3;
  logic [CW-1:0] o_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpu_prim_sequencer #(
    .VTX_W(VW),
    .CNT_W(CW)
  ) dut (
    .I_CLOCK          (clk),
    .I_LOCK           (lock),
    .I_CmdValid       (cv),
    .I_Cmd            (cmd),
    .I_PrimType       (pt),
    .I_VertexData     (vd),
    .I_GPUStallSignal (gs),
    .O_Stall          (o_stall),
    .O_PrimValid      (o_pv),
    .O_VertexV1       (o_v1),
    .O_VertexV2       (o_v2),
    .O_VertexV3       (o_v3),
    .O_PrimOpen       (o_open),
    .O_PrimCount      (o_cnt),
    .O_Error          (o_err)
  );

  // Reference model: vertex list of the open primitive, pending triangle.
  logic          m_open, m_strip, m_pv, m_err;
  logic [VW-1:0] q[$];
  int            m_k;
  logic [VW-1:0] m_v1, m_v2, m_v3;
  logic [CW-1:0] m_cnt;
  logic          seen_stall, m_stall;

  task automatic model_reset();
    m_open = 0; m_strip = 0; m_pv = 0; m_err = 0;
    q.delete(); m_k = 0;
    m_v1 = '0; m_v2 = '0; m_v3 = '0; m_cnt = '0;
  endtask

  task automatic emit(input logic [VW-1:0] a, b, c, inout logic nt);
    m_v1 = a; m_v2 = b; m_v3 = c; nt = 1'b1;
  endtask

  task automatic model_edge();
    logic stall, take, nt;
    if (!lock) begin
      model_reset();
      return;
    end
    stall = m_pv & gs;
    take  = m_pv & ~gs;
    nt    = 1'b0;
    if (cv && !stall) begin
      case (cmd)
        CMD_BEGIN: begin
          if (m_open) m_err = 1;
          m_open = 1;
`ifdef GPU_TRISTRIP_EN
          m_strip = pt;
`else
          m_strip = 0;
`endif
          q.delete(); m_k = 0;
        end
        CMD_VERTEX: begin
          if (!m_open) m_err = 1;
          else begin
            q.push_back(vd);
            if (q.size() == 3) begin
              if (!m_strip) begin
                emit(q[0], q[1], q[2], nt);
                q.delete();
              end else begin
                if (m_k % 2 == 0) emit(q[0], q[1], q[2], nt);
                else              emit(q[1], q[0], q[2], nt);
                m_k++;
                void'(q.pop_front());
              end
            end
          end
        end
        CMD_END: begin
          if (!m_open) m_err = 1;
          else begin
            if (!m_strip && q.size() != 0) m_err = 1;
            if (m_strip && q.size() == 1) m_err = 1;
            m_open = 0;
            q.delete();
          end
        end
        default: ;
      endcase
    end
    if (take) m_cnt = m_cnt + 1'b1;
    if (nt) m_pv = 1'b1;
    else if (take) m_pv = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One active (falling) edge with the given inputs.
  task automatic cyc(input logic v, input logic [1:0] c, input logic p,
                     input logic [VW-1:0] d, input logic s, input logic l);
    cv = v; cmd = c; pt = p; vd = d; gs = s; lock = l;
    #1;
    seen_stall = o_stall;
    m_stall    = m_pv & s;
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".stall"}, 64'(seen_stall), 64'(m_stall));
    chk({tag, ".pv"},    64'(o_pv),   64'(m_pv));
    chk({tag, ".v1"},    64'(o_v1),   64'(m_v1));
    chk({tag, ".v2"},    64'(o_v2),   64'(m_v2));
    chk({tag, ".v3"},    64'(o_v3),   64'(m_v3));
    chk({tag, ".open"},  64'(o_open), 64'(m_open));
    chk({tag, ".cnt"},   64'(o_cnt),  64'(m_cnt));
    chk({tag, ".err"},   64'(o_err),  64'(m_err));
  endtask

  task automatic chk_tri(input string tag, input logic [VW-1:0] a, b, c);
    chk({tag, ".pv"}, 64'(o_pv), 64'(1));
    chk({tag, ".v1"}, 64'(o_v1), 64'(a));
    chk({tag, ".v2"}, 64'(o_v2), 64'(b));
    chk({tag, ".v3"}, 64'(o_v3), 64'(c));
  endtask

  typedef struct {
    logic          v;
    logic [1:0]    c;
    logic [VW-1:0] d;
    logic          s, l;
    logic          es, epv;
    logic [VW-1:0] e1, e2, e3;
    logic          eo;
    logic [CW-1:0] ec;
    logic          ee;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic v, logic [1:0] c, int d, logic s, logic l,
                              logic es, logic epv, int e1, int e2, int e3,
                              logic eo, int ec, logic ee);
    vec_t r;
    r.v = v; r.c = c; r.d = VW'(d); r.s = s; r.l = l;
    r.es = es; r.epv = epv;
    r.e1 = VW'(e1); r.e2 = VW'(e2); r.e3 = VW'(e3);
    r.eo = eo; r.ec = CW'(ec); r.ee = ee;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string n;
    logic  l, v, p, s;
    logic [1:0] c;
    int r;

    model_reset();

    // reset, list, stall hold, protocol errors, reset with pending triangle
    tbl[0]  = mk(0, CMD_NOP,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, CMD_BEGIN,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, CMD_VERTEX, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, CMD_VERTEX, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, CMD_VERTEX, 3, 0, 1, 0, 1, 1, 2, 3, 1, 0, 0);
    tbl[5]  = mk(1, CMD_END,    0, 0, 1, 0, 0, 1, 2, 3, 0, 1, 0);
    tbl[6]  = mk(0, CMD_NOP,    0, 0, 1, 0, 0, 1, 2, 3, 0, 1, 0);
    tbl[7]  = mk(1, CMD_BEGIN,  0, 0, 1, 0, 0, 1, 2, 3, 1, 1, 0);
    tbl[8]  = mk(1, CMD_VERTEX, 1, 0, 1, 0, 0, 1, 2, 3, 1, 1, 0);
    tbl[9]  = mk(1, CMD_VERTEX, 2, 0, 1, 0, 0, 1, 2, 3, 1, 1, 0);
    tbl[10] = mk(1, CMD_VERTEX, 3, 1, 1, 0, 1, 1, 2, 3, 1, 1, 0);
    for (int i = 11; i < 15; i++)
      tbl[i] = mk(1, CMD_VERTEX, 4, 1, 1, 1, 1, 1, 2, 3, 1, 1, 0);
    tbl[15] = mk(1, CMD_VERTEX, 4, 0, 1, 0, 0, 1, 2, 3, 1, 2, 0);
    tbl[16] = mk(1, CMD_END,    0, 0, 1, 0, 0, 1, 2, 3, 0, 2, 1);
    tbl[17] = mk(0, CMD_NOP,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, CMD_VERTEX, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, CMD_NOP,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, CMD_BEGIN,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(1, CMD_VERTEX, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(1, CMD_END,    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[23] = mk(0, CMD_NOP,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = mk(1, CMD_BEGIN,  0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[25] = mk(1, CMD_VERTEX, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[26] = mk(1, CMD_VERTEX, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[27] = mk(1, CMD_VERTEX, 3, 1, 1, 0, 1, 1, 2, 3, 1, 0, 0);
    tbl[28] = mk(1, CMD_VERTEX, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 29; i++) begin
      cyc(tbl[i].v, tbl[i].c, 1'b0, tbl[i].d, tbl[i].s, tbl[i].l);
      n = $sformatf("tbl%0d", i);
      chk({n, ".stall"}, 64'(seen_stall), 64'(tbl[i].es));
      chk({n, ".pv"},    64'(o_pv),   64'(tbl[i].epv));
      chk({n, ".v1"},    64'(o_v1),   64'(tbl[i].e1));
      chk({n, ".v2"},    64'(o_v2),   64'(tbl[i].e2));
      chk({n, ".v3"},    64'(o_v3),   64'(tbl[i].e3));
      chk({n, ".open"},  64'(o_open), 64'(tbl[i].eo));
      chk({n, ".cnt"},   64'(o_cnt),  64'(tbl[i].ec));
      chk({n, ".err"},   64'(o_err),  64'(tbl[i].ee));
    end

`ifdef GPU_TRISTRIP_EN
    // strip winding: (A,B,C), (C,B,D), (C,D,E) back to back
    cyc(0, CMD_NOP, 0, '0, 0, 0);
    cyc(1, CMD_BEGIN, 1, '0, 0, 1);
    cyc(1, CMD_VERTEX, 0, VW'('hA), 0, 1);
    cyc(1, CMD_VERTEX, 0, VW'('hB), 0, 1);
    cyc(1, CMD_VERTEX, 0, VW'('hC), 0, 1);
    chk_tri("strip0", VW'('hA), VW'('hB), VW'('hC));
    cyc(1, CMD_VERTEX, 0, VW'('hD), 0, 1);
    chk_tri("strip1", VW'('hC), VW'('hB), VW'('hD));
    cyc(1, CMD_VERTEX, 0, VW'('hE), 0, 1);
    chk_tri("strip2", VW'('hC), VW'('hD), VW'('hE));
    cyc(1, CMD_END, 0, '0, 0, 1);
    cyc(0, CMD_NOP, 0, '0, 0, 1);
    chk("strip.pv",  64'(o_pv),  64'(0));
    chk("strip.cnt", 64'(o_cnt), 64'(3));
    chk("strip.err", 64'(o_err), 64'(0));
`endif

    // counter wrap: 17 accepted triangles on a 4-bit counter
    cyc(0, CMD_NOP, 0, '0, 0, 0);
    cyc(1, CMD_BEGIN, 0, '0, 0, 1);
    for (int i = 0; i < 17; i++)
      for (int j = 1; j <= 3; j++)
        cyc(1, CMD_VERTEX, 0, VW'(3 * i + j), 0, 1);
    cyc(1, CMD_END, 0, '0, 0, 1);
    cyc(0, CMD_NOP, 0, '0, 0, 1);
    chk("wrap.cnt", 64'(o_cnt), 64'(1));
    chk("wrap.err", 64'(o_err), 64'(0));
    chk("wrap.pv",  64'(o_pv),  64'(0));

    // random traffic against the model
    cyc(0, CMD_NOP, 0, '0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      l = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 9);
      c = (r == 0) ? CMD_NOP : (r == 1) ? CMD_BEGIN :
          (r == 2) ? CMD_END : CMD_VERTEX;
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0);
      cyc(v, c, p, VW'($urandom), s, l);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
